// File: rtl/tick_meter_pkg.sv
// tick_meter_pkg: shared state encoding and default sizing for the tick period meter
package tick_meter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_e;
  localparam int DEF_WIDTH = 32;
  localparam logic [31:0] DEF_MAX_COUNT = 32'd12_000_000;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronizes an async line into clk and emits a one-cycle rise pulse
//   clk_i, rst_i (async, active-high) | async_i raw line
//   level_o synchronized level | rise_o combinational rise pulse
module sync_edge_det
  import tick_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: SYNC_STAGES must be >= 2");
  end
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0] fill_q;
  logic edge_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      fill_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      edge_q <= level_o;
    end
  end
  assign level_o = sync_q[SYNC_STAGES-1];
  // fill_q masks rises until both level_o and edge_q hold real samples, so a line
  // already high at reset release is not mistaken for a fresh edge
  assign rise_o = level_o & ~edge_q & fill_q[SYNC_STAGES];
endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk-cycle interval between rising edges of a strobe
//   clk_i, rst_i (async, active-high) | strobe_i async strobe | clr_i sync clear
//   period_o last interval | valid_o one-cycle update pulse
//   timeout_o sticky overrun flag | busy_o measuring
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter logic [31:0] MAX_COUNT   = DEF_MAX_COUNT,
  parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strobe_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             busy_o
);
  if (MAX_COUNT < 32'd2 || (WIDTH < 32 && (MAX_COUNT >> WIDTH) != 32'd0)) begin : g_bad_max
    $error("tick_period_meter: MAX_COUNT must be >= 2 and fit in WIDTH bits");
  end
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
  logic rise;
  state_e state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
  logic valid_q, valid_d, timeout_q, timeout_d;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(strobe_i),
    .level_o(),
    .rise_o (rise)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end
  // clr outranks rise, and rise outranks the overrun check so an edge landing
  // exactly at MAX_COUNT is still a valid measurement
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (clr_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (rise) begin
        state_d = ST_MEASURE;
        cnt_d   = WIDTH'(1);
      end
    end else if (rise) begin
      period_d = cnt_q;
      valid_d  = 1'b1;
      cnt_d    = WIDTH'(1);
    end else if (cnt_q == MAX_W) begin
      timeout_d = 1'b1;
      state_d   = ST_IDLE;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q == ST_MEASURE);
endmodule
